// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared LeNet5 datapath constants and elaboration helpers
package lenet_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // Number of bits needed to encode values 0 .. n-1 (minimum 0 for n <= 1)
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// rtl/pipe_reg_stage.sv - one valid+data stage of the elastic pipeline register chain
module pipe_reg_stage
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_flush,
    input  logic                  i_load,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    // i_load is this stage's ready; data only moves with a real word so bubbles never toggle it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_register_chain.sv
// rtl/pipe_register_chain.sv - DEPTH-stage elastic valid/ready register chain; PIPE_REG_OCC_EN adds occupancy port
module pipe_register_chain
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Enable,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
`ifdef PIPE_REG_OCC_EN
    ,
    output logic [clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic                  w_valid [DEPTH];
    logic [DATA_WIDTH-1:0] w_data  [DEPTH];
    logic [DEPTH:0]        w_ready;

    // Ready ripples back from the sink through every stage; this is the chain's critical path.
    // An empty stage is ready even when everything below it is stalled, which collapses bubbles.
    always_comb begin
        w_ready        = '0;
        w_ready[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_ready[i] = Enable & (~w_valid[i] | w_ready[i+1]);
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            logic                  w_up_valid;
            logic [DATA_WIDTH-1:0] w_up_data;

            if (g == 0) begin : g_head
                assign w_up_valid = in_valid;
                assign w_up_data  = in_data;
            end else begin : g_body
                assign w_up_valid = w_valid[g-1];
                assign w_up_data  = w_data[g-1];
            end

            pipe_reg_stage #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_stage (
                .clk    (clk),
                .reset  (reset),
                .i_flush(flush),
                .i_load (w_ready[g]),
                .i_valid(w_up_valid),
                .i_data (w_up_data),
                .o_valid(w_valid[g]),
                .o_data (w_data[g])
            );
        end
    endgenerate

    assign in_ready  = w_ready[0] & ~reset;
    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];

`ifdef PIPE_REG_OCC_EN
    localparam int OCC_W = clog2(DEPTH + 1);

    logic [OCC_W-1:0] r_occ;
    logic             w_push;
    logic             w_pop;

    // A pop only counts while enabled; internal bubble moves never change the count
    assign w_push = in_valid & in_ready;
    assign w_pop  = w_valid[DEPTH-1] & w_ready[DEPTH] & Enable;

    // Running count of valid stages, updated on the same edge the stages move
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
        end
    end

    assign occupancy = r_occ;
`endif

endmodule

// File: tb/tb_pipe_register_chain.sv
// tb/tb_pipe_register_chain.sv - directed self-checking bench for pipe_register_chain (DATA_WIDTH=8, DEPTH=3)
module tb_pipe_register_chain;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       Enable;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
`ifdef PIPE_REG_OCC_EN
    logic [1:0] occupancy;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_irdy;
        logic       e_ov;
        logic [7:0] e_od;
        logic       c_od;
        logic [1:0] e_occ;
    } row_t;

    pipe_register_chain #(
        .DATA_WIDTH(8),
        .DEPTH     (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Enable   (Enable),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
`ifdef PIPE_REG_OCC_EN
        ,
        .occupancy(occupancy)
`endif
    );

    always #5 clk = ~clk;

    task automatic apply(input row_t r);
        reset     = r.rst;
        Enable    = r.en;
        flush     = r.fl;
        in_valid  = r.iv;
        in_data   = r.id;
        out_ready = r.ordy;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t t[5];
        t = '{
            '{H,H,L,H,8'h5A,H, L,L,8'h00,H,2'd0},
            '{H,H,L,H,8'h5A,H, L,L,8'h00,H,2'd0},
            '{L,H,L,L,8'h00,H, H,L,8'h00,H,2'd0},
            '{L,H,L,L,8'h00,H, H,L,8'h00,H,2'd0},
            '{L,H,L,L,8'h00,H, H,L,8'h00,H,2'd0}
        };
        for (int i = 0; i < 5; i++) begin
            apply(t[i]);
            checks++;
            if (in_ready !== t[i].e_irdy) begin failures++; $display("FAIL reset[%0d] in_ready got=%b exp=%b", i, in_ready, t[i].e_irdy); end
            checks++;
            if (out_valid !== t[i].e_ov) begin failures++; $display("FAIL reset[%0d] out_valid got=%b exp=%b", i, out_valid, t[i].e_ov); end
            if (t[i].c_od) begin
                checks++;
                if (out_data !== t[i].e_od) begin failures++; $display("FAIL reset[%0d] out_data got=%h exp=%h", i, out_data, t[i].e_od); end
            end
`ifdef PIPE_REG_OCC_EN
            checks++;
            if (occupancy !== t[i].e_occ) begin failures++; $display("FAIL reset[%0d] occupancy got=%0d exp=%0d", i, occupancy, t[i].e_occ); end
`endif
            next_cycle();
        end
    endtask

    task automatic test_stream();
        row_t t[7];
        t = '{
            '{L,H,L,H,8'h11,H, H,L,8'h00,H,2'd0},
            '{L,H,L,H,8'h22,H, H,L,8'h00,H,2'd1},
            '{L,H,L,H,8'h33,H, H,L,8'h00,H,2'd2},
            '{L,H,L,L,8'h00,H, H,H,8'h11,H,2'd3},
            '{L,H,L,L,8'h00,H, H,H,8'h22,H,2'd2},
            '{L,H,L,L,8'h00,H, H,H,8'h33,H,2'd1},
            '{L,H,L,L,8'h00,H, H,L,8'h33,H,2'd0}
        };
        for (int i = 0; i < 7; i++) begin
            apply(t[i]);
            checks++;
            if (in_ready !== t[i].e_irdy) begin failures++; $display("FAIL stream[%0d] in_ready got=%b exp=%b", i, in_ready, t[i].e_irdy); end
            checks++;
            if (out_valid !== t[i].e_ov) begin failures++; $display("FAIL stream[%0d] out_valid got=%b exp=%b", i, out_valid, t[i].e_ov); end
            if (t[i].c_od) begin
                checks++;
                if (out_data !== t[i].e_od) begin failures++; $display("FAIL stream[%0d] out_data got=%h exp=%h", i, out_data, t[i].e_od); end
            end
`ifdef PIPE_REG_OCC_EN
            checks++;
            if (occupancy !== t[i].e_occ) begin failures++; $display("FAIL stream[%0d] occupancy got=%0d exp=%0d", i, occupancy, t[i].e_occ); end
`endif
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        row_t t[11];
        t = '{
            '{L,H,L,H,8'hA1,L, H,L,8'h33,H,2'd0},
            '{L,H,L,H,8'hA2,L, H,L,8'h33,H,2'd1},
            '{L,H,L,H,8'hA3,L, H,L,8'h33,H,2'd2},
            '{L,H,L,H,8'hA4,L, L,H,8'hA1,H,2'd3},
            '{L,H,L,H,8'hA4,L, L,H,8'hA1,H,2'd3},
            '{L,H,L,H,8'hA4,L, L,H,8'hA1,H,2'd3},
            '{L,H,L,H,8'hA4,H, H,H,8'hA1,H,2'd3},
            '{L,H,L,L,8'h00,H, H,H,8'hA2,H,2'd3},
            '{L,H,L,L,8'h00,H, H,H,8'hA3,H,2'd2},
            '{L,H,L,L,8'h00,H, H,H,8'hA4,H,2'd1},
            '{L,H,L,L,8'h00,H, H,L,8'hA4,H,2'd0}
        };
        for (int i = 0; i < 11; i++) begin
            apply(t[i]);
            checks++;
            if (in_ready !== t[i].e_irdy) begin failures++; $display("FAIL backpressure[%0d] in_ready got=%b exp=%b", i, in_ready, t[i].e_irdy); end
            checks++;
            if (out_valid !== t[i].e_ov) begin failures++; $display("FAIL backpressure[%0d] out_valid got=%b exp=%b", i, out_valid, t[i].e_ov); end
            if (t[i].c_od) begin
                checks++;
                if (out_data !== t[i].e_od) begin failures++; $display("FAIL backpressure[%0d] out_data got=%h exp=%h", i, out_data, t[i].e_od); end
            end
`ifdef PIPE_REG_OCC_EN
            checks++;
            if (occupancy !== t[i].e_occ) begin failures++; $display("FAIL backpressure[%0d] occupancy got=%0d exp=%0d", i, occupancy, t[i].e_occ); end
`endif
            next_cycle();
        end
    endtask

    task automatic test_full_simultaneous();
        row_t t[9];
        t = '{
            '{L,H,L,H,8'hB1,L, H,L,8'hA4,H,2'd0},
            '{L,H,L,H,8'hB2,L, H,L,8'hA4,H,2'd1},
            '{L,H,L,H,8'hB3,L, H,L,8'hA4,H,2'd2},
            '{L,H,L,H,8'hB4,H, H,H,8'hB1,H,2'd3},
            '{L,H,L,L,8'h00,L, L,H,8'hB2,H,2'd3},
            '{L,H,L,L,8'h00,H, H,H,8'hB2,H,2'd3},
            '{L,H,L,L,8'h00,H, H,H,8'hB3,H,2'd2},
            '{L,H,L,L,8'h00,H, H,H,8'hB4,H,2'd1},
            '{L,H,L,L,8'h00,H, H,L,8'hB4,H,2'd0}
        };
        for (int i = 0; i < 9; i++) begin
            apply(t[i]);
            checks++;
            if (in_ready !== t[i].e_irdy) begin failures++; $display("FAIL full_simul[%0d] in_ready got=%b exp=%b", i, in_ready, t[i].e_irdy); end
            checks++;
            if (out_valid !== t[i].e_ov) begin failures++; $display("FAIL full_simul[%0d] out_valid got=%b exp=%b", i, out_valid, t[i].e_ov); end
            if (t[i].c_od) begin
                checks++;
                if (out_data !== t[i].e_od) begin failures++; $display("FAIL full_simul[%0d] out_data got=%h exp=%h", i, out_data, t[i].e_od); end
            end
`ifdef PIPE_REG_OCC_EN
            checks++;
            if (occupancy !== t[i].e_occ) begin failures++; $display("FAIL full_simul[%0d] occupancy got=%0d exp=%0d", i, occupancy, t[i].e_occ); end
`endif
            next_cycle();
        end
    endtask

    task automatic test_flush();
        row_t t[11];
        t = '{
            '{L,H,L,H,8'hC1,H, H,L,8'hB4,H,2'd0},
            '{L,H,L,H,8'hC2,H, H,L,8'hB4,H,2'd1},
            '{L,H,H,H,8'hC3,H, H,L,8'hB4,H,2'd2},
            '{L,H,L,L,8'h00,H, H,L,8'hB4,H,2'd0},
            '{L,H,L,L,8'h00,H, H,L,8'hB4,H,2'd0},
            '{L,H,L,L,8'h00,H, H,L,8'hB4,H,2'd0},
            '{L,H,L,H,8'hE1,H, H,L,8'hB4,H,2'd0},
            '{L,L,H,L,8'h00,H, L,L,8'hB4,H,2'd1},
            '{L,H,L,L,8'h00,H, H,L,8'hB4,H,2'd0},
            '{L,H,L,L,8'h00,H, H,L,8'hB4,H,2'd0},
            '{L,H,L,L,8'h00,H, H,L,8'hB4,H,2'd0}
        };
        for (int i = 0; i < 11; i++) begin
            apply(t[i]);
            checks++;
            if (in_ready !== t[i].e_irdy) begin failures++; $display("FAIL flush[%0d] in_ready got=%b exp=%b", i, in_ready, t[i].e_irdy); end
            checks++;
            if (out_valid !== t[i].e_ov) begin failures++; $display("FAIL flush[%0d] out_valid got=%b exp=%b", i, out_valid, t[i].e_ov); end
            if (t[i].c_od) begin
                checks++;
                if (out_data !== t[i].e_od) begin failures++; $display("FAIL flush[%0d] out_data got=%h exp=%h", i, out_data, t[i].e_od); end
            end
`ifdef PIPE_REG_OCC_EN
            checks++;
            if (occupancy !== t[i].e_occ) begin failures++; $display("FAIL flush[%0d] occupancy got=%0d exp=%0d", i, occupancy, t[i].e_occ); end
`endif
            next_cycle();
        end
    endtask

    task automatic test_enable();
        row_t t[12];
        t = '{
            '{L,H,L,H,8'hD1,H, H,L,8'hB4,H,2'd0},
            '{L,H,L,H,8'hD2,H, H,L,8'hB4,H,2'd1},
            '{L,H,L,H,8'hD3,H, H,L,8'hB4,H,2'd2},
            '{L,L,L,H,8'hD4,H, L,H,8'hD1,H,2'd3},
            '{L,L,L,H,8'hD4,H, L,H,8'hD1,H,2'd3},
            '{L,L,L,H,8'hD4,H, L,H,8'hD1,H,2'd3},
            '{L,L,L,H,8'hD4,H, L,H,8'hD1,H,2'd3},
            '{L,H,L,H,8'hD4,H, H,H,8'hD1,H,2'd3},
            '{L,H,L,L,8'h00,H, H,H,8'hD2,H,2'd3},
            '{L,H,L,L,8'h00,H, H,H,8'hD3,H,2'd2},
            '{L,H,L,L,8'h00,H, H,H,8'hD4,H,2'd1},
            '{L,H,L,L,8'h00,H, H,L,8'hD4,H,2'd0}
        };
        for (int i = 0; i < 12; i++) begin
            apply(t[i]);
            checks++;
            if (in_ready !== t[i].e_irdy) begin failures++; $display("FAIL enable[%0d] in_ready got=%b exp=%b", i, in_ready, t[i].e_irdy); end
            checks++;
            if (out_valid !== t[i].e_ov) begin failures++; $display("FAIL enable[%0d] out_valid got=%b exp=%b", i, out_valid, t[i].e_ov); end
            if (t[i].c_od) begin
                checks++;
                if (out_data !== t[i].e_od) begin failures++; $display("FAIL enable[%0d] out_data got=%h exp=%h", i, out_data, t[i].e_od); end
            end
`ifdef PIPE_REG_OCC_EN
            checks++;
            if (occupancy !== t[i].e_occ) begin failures++; $display("FAIL enable[%0d] occupancy got=%0d exp=%0d", i, occupancy, t[i].e_occ); end
`endif
            next_cycle();
        end
    endtask

    task automatic test_reset_midstream();
        row_t t[6];
        t = '{
            '{L,H,L,H,8'hF1,H, H,L,8'hD4,H,2'd0},
            '{L,H,L,H,8'hF2,H, H,L,8'hD4,H,2'd1},
            '{H,H,H,H,8'hF3,H, L,L,8'hD4,H,2'd2},
            '{L,H,L,L,8'h00,H, H,L,8'h00,H,2'd0},
            '{L,H,L,L,8'h00,H, H,L,8'h00,H,2'd0},
            '{L,H,L,L,8'h00,H, H,L,8'h00,H,2'd0}
        };
        for (int i = 0; i < 6; i++) begin
            apply(t[i]);
            checks++;
            if (in_ready !== t[i].e_irdy) begin failures++; $display("FAIL reset_mid[%0d] in_ready got=%b exp=%b", i, in_ready, t[i].e_irdy); end
            checks++;
            if (out_valid !== t[i].e_ov) begin failures++; $display("FAIL reset_mid[%0d] out_valid got=%b exp=%b", i, out_valid, t[i].e_ov); end
            if (t[i].c_od) begin
                checks++;
                if (out_data !== t[i].e_od) begin failures++; $display("FAIL reset_mid[%0d] out_data got=%h exp=%h", i, out_data, t[i].e_od); end
            end
`ifdef PIPE_REG_OCC_EN
            checks++;
            if (occupancy !== t[i].e_occ) begin failures++; $display("FAIL reset_mid[%0d] occupancy got=%0d exp=%0d", i, occupancy, t[i].e_occ); end
`endif
            next_cycle();
        end
    endtask

    initial begin
        reset     = 1'b1;
        Enable    = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        next_cycle();

        test_reset();
        test_stream();
        test_backpressure();
        test_full_simultaneous();
        test_flush();
        test_enable();
        test_reset_midstream();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
